mem_access_unit: RTL

//  Memory-side stage downstream of the multicycle controller. It turns each single-cycle

---
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-side stage for the multicycle controller. Each single-cycle access
// request (instruction fetch or data load/store) becomes a req/gnt/rvalid
// transaction on a variable-latency memory port. Read data lands in IR for
// fetches and MDR for data loads. busy/done let the controller stall its FSM.
module mem_access_unit #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic          req_iord,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          iord_q;
    logic          capture;
    logic          fail;
    logic          accept;

    // A request is only taken in idle; a misaligned one never reaches memory.
    assign accept = (state == S_IDLE) && req_valid && (req_addr[1:0] == 2'b00);

    // busy is the only combinational output.
    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the capture and error decisions for this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        next_state = state;
        capture    = 1'b0;
        fail       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_addr[1:0] != 2'b00) begin
                        next_state = S_DONE;
                        fail       = 1'b1;
                    end else begin
                        next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // No timeout here: the memory may stall the grant indefinitely.
                if (mem_gnt) begin
                    if (mem_we) begin
                        next_state = S_DONE;
                    end else if (mem_rvalid) begin
                        capture    = 1'b1;
                        next_state = S_DONE;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // rvalid takes priority over a timeout landing in the same cycle.
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    next_state = S_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    fail       = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Wait-state cycle counter; cleared whenever the FSM is not waiting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (state == S_WAIT && next_state == S_WAIT) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Registered outputs: handshake, memory port fields and the IR/MDR capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iord_q    <= 1'b0;
            ir        <= '0;
            mdr       <= '0;
        end else begin
            done    <= (next_state == S_DONE);
            err     <= fail;
            mem_req <= (next_state == S_REQ);

            // Port fields are loaded once on acceptance and held through S_REQ.
            if (accept) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[AW-1:2], 2'b00};
                mem_wdata <= req_wdata;
                iord_q    <= req_iord;
            end else if (state == S_REQ && mem_gnt) begin
                mem_we <= 1'b0;
            end

            // Exactly one of IR/MDR is written per completed read.
            if (capture) begin
                if (iord_q) begin
                    mdr <= mem_rdata;
                end else begin
                    ir <= mem_rdata;
                end
            end
        end
    end

endmodule
